serial_in_parallel_out_receiver: RTL and testbench

Downstream companion of the 8-bit PISO shift register. Captures its MSB-first serial stream under a frame-start marker and a per-bit strobe, then assembles DATA_WIDTH-bit words. Completed words go to a consumer through a registered valid/ready output stage. Overrun and framing faults are flagged with sticky error bits. This block closes the parallel -> serial -> parallel loop used by the shift-register test harnesses.

---
 rtl/serial_in_parallel_out_receiver.sv | 143 ++++++++++++++
 tb/tb_serial_in_parallel_out_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_in_parallel_out_receiver.sv
// ---------------------------------------------------------------------------
// serial_in_parallel_out_receiver
//
// Receives the MSB-first serial stream produced by the PISO shift register
// and reassembles DATA_WIDTH-bit words. A one-cycle Frame_Start_In arms
// capture; each Bit_Strobe_In cycle then samples one bit of Serial_Data_In.
// Completed words are presented through a registered valid/ready stage.
//
// Handshake: a word is transferred on every rising edge where
// Data_Valid_Out && Data_Ready_In. While Data_Valid_Out is high and the word
// has not been accepted, Parallel_Data_Out does not change.
//
// Ports
//   Clk_In             clock, all state updates on the rising edge
//   Reset_In           asynchronous, active-high reset
//   Enable_In          freezes the capture FSM and shift register when low
//   Frame_Start_In     one-cycle marker that arms capture of a new word
//   Bit_Strobe_In      Serial_Data_In carries a valid bit this cycle
//   Serial_Data_In     serial data, MSB first
//   Parallel_Data_Out  last completed word
//   Data_Valid_Out     Parallel_Data_Out holds an unconsumed word
//   Data_Ready_In      consumer accepts the word when valid && ready
//   Busy_Out           high while a word is being shifted in
//   Overrun_Error_Out  sticky: word completed while previous one unconsumed
//   Frame_Error_Out    sticky: Frame_Start_In arrived mid-word
//   Clear_Error_In     synchronous clear of both sticky errors
//   state_dbg          capture FSM state (0 = IDLE, 1 = SHIFT)
// ---------------------------------------------------------------------------
module serial_in_parallel_out_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Frame_Start_In,
  input  logic                  Bit_Strobe_In,
  input  logic                  Serial_Data_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Data_Valid_Out,
  input  logic                  Data_Ready_In,
  output logic                  Busy_Out,
  output logic                  Overrun_Error_Out,
  output logic                  Frame_Error_Out,
  input  logic                  Clear_Error_In,
  output logic                  state_dbg
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic                  sample;
  logic                  complete;
  logic                  accept;
  logic                  overrun_set;
  logic                  frame_set;
  logic [DATA_WIDTH-1:0] next_word;

  // A frame start inside SHIFT restarts the word, so it masks any strobe
  // arriving in the same cycle.
  assign sample      = Enable_In && (state == SHIFT) && !Frame_Start_In && Bit_Strobe_In;
  assign complete    = sample && (bit_cnt == LAST_CNT);
  assign next_word   = {shift_reg[DATA_WIDTH-2:0], Serial_Data_In};
  assign accept      = Data_Valid_Out && Data_Ready_In;
  // A completing word is only dropped when the held word is not leaving
  // on this same edge.
  assign overrun_set = complete && Data_Valid_Out && !Data_Ready_In;
  assign frame_set   = Enable_In && (state == SHIFT) && Frame_Start_In;

  assign Busy_Out  = (state == SHIFT);
  assign state_dbg = state;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      Parallel_Data_Out <= '0;
      Data_Valid_Out    <= 1'b0;
      Overrun_Error_Out <= 1'b0;
      Frame_Error_Out   <= 1'b0;
    end else begin
      // Capture FSM
      if (Enable_In) begin
        case (state)
          IDLE: begin
            if (Frame_Start_In) begin
              state     <= SHIFT;
              bit_cnt   <= '0;
              shift_reg <= '0;
            end
          end
          SHIFT: begin
            if (Frame_Start_In) begin
              bit_cnt   <= '0;
              shift_reg <= '0;
            end else if (Bit_Strobe_In) begin
              shift_reg <= next_word;
              if (bit_cnt == LAST_CNT) begin
                state   <= IDLE;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        endcase
      end

      // Output stage
      if (complete && !overrun_set) begin
        Parallel_Data_Out <= next_word;
        Data_Valid_Out    <= 1'b1;
      end else if (accept) begin
        Data_Valid_Out <= 1'b0;
      end

      // Sticky errors: a new event outranks a same-cycle clear.
      if (overrun_set)
        Overrun_Error_Out <= 1'b1;
      else if (Clear_Error_In)
        Overrun_Error_Out <= 1'b0;

      if (frame_set)
        Frame_Error_Out <= 1'b1;
      else if (Clear_Error_In)
        Frame_Error_Out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_in_parallel_out_receiver.sv
module tb_serial_in_parallel_out_receiver;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en, fs, strb, sd, rdy, clr;
  logic [W-1:0] pdata;
  logic         valid, busy, ovr, ferr, st;

  serial_in_parallel_out_receiver #(.DATA_WIDTH(W)) dut (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Frame_Start_In    (fs),
    .Bit_Strobe_In     (strb),
    .Serial_Data_In    (sd),
    .Parallel_Data_Out (pdata),
    .Data_Valid_Out    (valid),
    .Data_Ready_In     (rdy),
    .Busy_Out          (busy),
    .Overrun_Error_Out (ovr),
    .Frame_Error_Out   (ferr),
    .Clear_Error_In    (clr),
    .state_dbg         (st)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Word-level view: an armed frame collects bits as a number; the output
  // side is a single-entry holding slot with valid/ready rules.
  bit m_armed;
  int m_nbits;
  int m_acc;
  bit m_valid;
  int m_data;
  bit m_ovr;
  bit m_ferr;
  logic [W-1:0] exp_q[$];   // completed words in order, for explicit checks

  function automatic void model_reset();
    m_armed = 0; m_nbits = 0; m_acc = 0;
    m_valid = 0; m_data = 0; m_ovr = 0; m_ferr = 0;
  endfunction

  function automatic void model_edge(bit f, bit s, bit d, bit e, bit r, bit c);
    bit comp = 0;
    bit fe = 0;
    bit ov = 0;
    int word = 0;
    if (e) begin
      if (f) begin
        if (m_armed) fe = 1;
        m_armed = 1; m_nbits = 0; m_acc = 0;
      end else if (m_armed && s) begin
        m_acc = (m_acc * 2 + int'(d)) % (1 << W);
        m_nbits++;
        if (m_nbits == W) begin
          comp = 1; word = m_acc; m_armed = 0;
        end
      end
    end
    if (comp) begin
      exp_q.push_back(W'(word));
      if (m_valid && !r) ov = 1;
      else begin m_data = word; m_valid = 1; end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_ovr  = ov | (m_ovr & !c);
    m_ferr = fe | (m_ferr & !c);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(pdata), 32'(m_data));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".busy"},  32'(busy),  32'(m_armed));
    check({tag, ".state"}, 32'(st),    32'(m_armed));
    check({tag, ".ovr"},   32'(ovr),   32'(m_ovr));
    check({tag, ".ferr"},  32'(ferr),  32'(m_ferr));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; outputs are sampled at posedge+1.
  task automatic step(input string tag, input bit f, input bit s, input bit d,
                      input bit e, input bit c);
    fs = f; strb = s; sd = d; en = e; clr = c;
    @(posedge clk);
    model_edge(f, s, d, e, rdy, c);
    #1;
    check_all(tag);
    fs = 0; strb = 0; clr = 0;
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w, input bit gaps);
    logic [W-1:0] v;
    v = w;
    step(tag, 1, 0, 0, 1, 0);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 2) == 0)
        step(tag, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
      step(tag, 0, 1, v[i], 1, 0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #3;
    model_reset();
    exp_q.delete();
    check_all(tag);
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    en = 1; fs = 0; strb = 0; sd = 0; rdy = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // 1: A5 held until ready
    rdy = 0;
    send_word("t1", 8'hA5, 0);
    check("t1.word", 32'(pdata), 32'hA5);
    check("t1.valid_on_last", 32'(valid), 32'd1);
    repeat (3) step("t1.hold", 0, 0, 0, 1, 0);
    rdy = 1;
    step("t1.accept", 0, 0, 0, 1, 0);
    check("t1.valid_drop", 32'(valid), 32'd0);

    // 2: back-to-back with ready tied high
    rdy = 1;
    exp_q.delete();
    send_word("t2a", 8'h3C, 0);
    send_word("t2b", 8'hC3, 0);
    step("t2.tail", 0, 0, 0, 1, 0);
    check("t2.count", 32'(exp_q.size()), 32'd2);
    check("t2.first", 32'(exp_q[0]), 32'h3C);
    check("t2.second", 32'(pdata), 32'hC3);

    // 3: overrun
    rdy = 0;
    send_word("t3a", 8'h11, 1);
    send_word("t3b", 8'h22, 1);
    check("t3.kept", 32'(pdata), 32'h11);
    check("t3.ovr", 32'(ovr), 32'd1);
    step("t3.clear", 0, 0, 0, 1, 1);
    check("t3.ovr_clr", 32'(ovr), 32'd0);
    rdy = 1;
    step("t3.drain", 0, 0, 0, 1, 0);

    // 4: frame error, restart, F0
    step("t4.fs", 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("t4.part", 0, 1, 1'($urandom_range(0, 1)), 1, 0);
    send_word("t4", 8'hF0, 0);
    check("t4.ferr", 32'(ferr), 32'd1);
    check("t4.word", 32'(pdata), 32'hF0);
    // error event in the same cycle as clear: set wins
    step("t4.fs2", 1, 0, 0, 1, 0);
    step("t4.set_vs_clr", 1, 0, 0, 1, 1);
    check("t4.set_wins", 32'(ferr), 32'd1);
    step("t4.clr", 0, 0, 0, 1, 1);

    // 5: enable low mid-word with strobes toggling
    v = 8'h5A;
    step("t5.fs", 1, 0, 0, 1, 0);
    for (int i = W - 1; i >= 4; i--) step("t5.hi", 0, 1, v[i], 1, 0);
    for (int i = 0; i < 5; i++) step("t5.frz", 0, 1'(i % 2 == 0), 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 3; i >= 0; i--) step("t5.lo", 0, 1, v[i], 1, 0);
    check("t5.word", 32'(pdata), 32'h5A);
    step("t5.drain", 0, 0, 0, 1, 0);

    // 6: reset mid-word with a pending valid word
    rdy = 0;
    send_word("t6a", 8'h99, 0);
    v = 8'h00;
    step("t6.fs", 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("t6.part", 0, 1, 1'($urandom_range(0, 1)), 1, 0);
    do_reset("t6.rst");
    check("t6.data0", 32'(pdata), 32'd0);
    check("t6.valid0", 32'(valid), 32'd0);
    @(posedge clk); #1;
    rdy = 1;
    send_word("t6b", 8'h81, 0);
    check("t6.word", 32'(pdata), 32'h81);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rdy = 1'($urandom_range(0, 1));
      step("rand",
           1'($urandom_range(0, 13) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
